// File: rtl/pipelined_processor_pkg.sv
// Shared constants, instruction field positions and pipeline register layouts
// for the five-stage 16-bit core.
package pipelined_processor_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 12;
  localparam int MEM_WORDS = 4096;
  localparam int REG_COUNT = 8;
  localparam int REG_AW    = 3;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h020;

  // Opcodes; anything not listed behaves as a NOP.
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_NOT = 5'b00011;
  localparam logic [4:0] OP_LDD = 5'b00100;
  localparam logic [4:0] OP_STD = 5'b01100;
  localparam logic [4:0] OP_ADD = 5'b11001;

  // Instruction word fields: [15:11] opcode, [10:8] Rsrc, [7:5] Rdst.
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 11;
  localparam int RSRC_HI = 10;
  localparam int RSRC_LO = 8;
  localparam int RDST_HI = 7;
  localparam int RDST_LO = 5;

  // ID/EX: decoded opcode plus both operand values read in ID.
  typedef struct packed {
    logic [4:0]        op;
    logic [REG_AW-1:0] rdst;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] dst_val;
  } id_ex_t;

  // EX/MEM: ALU result, memory address and store data.
  typedef struct packed {
    logic [4:0]        op;
    logic [REG_AW-1:0] rdst;
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] st_data;
  } ex_mem_t;

  // MEM/WB: register write request.
  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rdst;
    logic [DATA_W-1:0] data;
  } mem_wb_t;

  // True for opcodes that produce a register result.
  function automatic logic writes_reg(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_NOT) || (op == OP_LDD);
  endfunction

endpackage

// File: rtl/pipelined_processor_memory.sv
// Unified 4096x16 word memory with two combinational read ports (fetch, data)
// and a single write port shared by the host loader and core stores.
module pipelined_processor_memory
  import pipelined_processor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_fm,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              st_we,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_data
);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  // Write arbitration: the loader wins over a store in the same cycle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = st_addr;
    wr_data_d = st_data;
    if (ld_we) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ld_addr;
      wr_data_d = ld_data;
    end else if (st_we) begin
      wr_en_d = 1'b1;
    end
  end

  // Storage update; a loader clear overrides any write.
  always_ff @(posedge clk) begin
    if (rst_fm) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign if_data = mem_q[if_addr];
  assign d_data  = mem_q[d_addr];

endmodule

// File: rtl/pipelined_processor_register_file.sv
// 8x16 register file: one write port, two bypassed read ports for ID and a
// debug read port. Reset loads R[n] = n.
module pipelined_processor_register_file
  import pipelined_processor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];

  // Next register contents: apply the write-back port.
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // Register array; reset gives each register its own index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < REG_COUNT; n++) regs_q[n] <= DATA_W'(n);
    end else begin
      regs_q <= regs_d;
    end
  end

  // ID reads see the value being written back this cycle (write-before-read).
  always_comb begin
    rd0 = (we && (waddr == ra0)) ? wdata : regs_q[ra0];
    rd1 = (we && (waddr == ra1)) ? wdata : regs_q[ra1];
  end

  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/pipelined_processor.sv
// Five-stage in-order 16-bit core (IF/ID/EX/MEM/WB). No hazard detection or
// forwarding: software must space dependent instructions by two slots.
module pipelined_processor
  import pipelined_processor_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    write_addr,
  output logic [15:0]   result,
  input  logic          write_enable_fm,
  input  logic          rst_fm,
  input  logic [15:0]   write_data_fm,
  input  logic [31:0]   write_addr_fm,
  output logic [15:0]   instruction,
  output logic          mem_write,
  output logic [15:0]   show
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] if_id_q, if_id_d;
  id_ex_t            id_ex_q, id_ex_d;
  ex_mem_t           ex_mem_q, ex_mem_d;
  mem_wb_t           mem_wb_q, mem_wb_d;

  logic [DATA_W-1:0] rf_src, rf_dst;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] alu_res;
  logic              unused_bits;

  pipelined_processor_register_file u_rf (
    .clk      (clk),
    .rst      (reset),
    .we       (mem_wb_q.we),
    .waddr    (mem_wb_q.rdst),
    .wdata    (mem_wb_q.data),
    .ra0      (if_id_q[RSRC_HI:RSRC_LO]),
    .rd0      (rf_src),
    .ra1      (if_id_q[RDST_HI:RDST_LO]),
    .rd1      (rf_dst),
    .dbg_addr (write_addr),
    .dbg_data (result)
  );

  pipelined_processor_memory u_mem (
    .clk     (clk),
    .rst_fm  (rst_fm),
    .ld_we   (write_enable_fm),
    .ld_addr (write_addr_fm[ADDR_W-1:0]),
    .ld_data (write_data_fm),
    .st_we   (mem_write),
    .st_addr (ex_mem_q.addr),
    .st_data (ex_mem_q.st_data),
    .if_addr (pc_q),
    .if_data (instruction),
    .d_addr  (ex_mem_q.addr),
    .d_data  (load_data)
  );

  // IF and ID: fetch M[PC] and decode/read operands.
  always_comb begin
    pc_d            = pc_q + 1'b1;
    if_id_d         = instruction;
    id_ex_d.op      = if_id_q[OPC_HI:OPC_LO];
    id_ex_d.rdst    = if_id_q[RDST_HI:RDST_LO];
    id_ex_d.src_val = rf_src;
    id_ex_d.dst_val = rf_dst;
  end

  // EX: ALU and address selection; show is zero for non-ALU instructions.
  always_comb begin
    alu_res = '0;
    case (id_ex_q.op)
      OP_ADD:  alu_res = id_ex_q.src_val + id_ex_q.dst_val;
      OP_NOT:  alu_res = ~id_ex_q.dst_val;
      default: alu_res = '0;
    endcase
    ex_mem_d.op      = id_ex_q.op;
    ex_mem_d.rdst    = id_ex_q.rdst;
    ex_mem_d.alu     = alu_res;
    ex_mem_d.addr    = (id_ex_q.op == OP_STD) ? id_ex_q.dst_val[ADDR_W-1:0]
                                              : id_ex_q.src_val[ADDR_W-1:0];
    ex_mem_d.st_data = id_ex_q.src_val;
    show             = alu_res;
  end

  // MEM: store request and load/ALU result selection for write-back.
  always_comb begin
    mem_write     = (ex_mem_q.op == OP_STD);
    mem_wb_d.we   = writes_reg(ex_mem_q.op);
    mem_wb_d.rdst = ex_mem_q.rdst;
    mem_wb_d.data = (ex_mem_q.op == OP_LDD) ? load_data : ex_mem_q.alu;
  end

  // PC and pipeline registers; reset squashes everything in flight to NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      if_id_q  <= '0;
      id_ex_q  <= '{op: OP_NOP, default: '0};
      ex_mem_q <= '{op: OP_NOP, default: '0};
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  // Loader address bits above the array and instruction bits [4:0] are don't-care.
  assign unused_bits = ^{write_addr_fm[31:ADDR_W], if_id_q[4:0]};

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed bench for pipelined_processor: small programs loaded under reset,
// results read back through the debug register port.
module tb_pipelined_processor;

  logic        clk;
  logic        reset;
  logic [2:0]  write_addr;
  logic [15:0] result;
  logic        write_enable_fm;
  logic        rst_fm;
  logic [15:0] write_data_fm;
  logic [31:0] write_addr_fm;
  logic [15:0] instruction;
  logic        mem_write;
  logic [15:0] show;

  int          checks;
  int          errors;
  logic [15:0] exp_r [8];

  pipelined_processor dut (
    .clk             (clk),
    .reset           (reset),
    .write_addr      (write_addr),
    .result          (result),
    .write_enable_fm (write_enable_fm),
    .rst_fm          (rst_fm),
    .write_data_fm   (write_data_fm),
    .write_addr_fm   (write_addr_fm),
    .instruction     (instruction),
    .mem_write       (mem_write),
    .show            (show)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [11:0] a, input logic [15:0] d);
    write_addr_fm   = 32'(a);
    write_data_fm   = d;
    write_enable_fm = 1'b1;
    run_edges(1);
    write_enable_fm = 1'b0;
  endtask

  task automatic clear_mem();
    rst_fm = 1'b1;
    run_edges(1);
    rst_fm = 1'b0;
  endtask

  task automatic set_exp_default();
    for (int i = 0; i < 8; i++) exp_r[i] = 16'(i);
  endtask

  // Hold core in reset, clear memory, reset expected register image.
  task automatic begin_test();
    reset = 1'b1;
    set_exp_default();
    run_edges(1);
    clear_mem();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      write_addr = 3'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), result, exp_r[i]);
    end
  endtask

  // Directed test sequence
  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    rst_fm          = 1'b0;
    write_enable_fm = 1'b0;
    write_data_fm   = '0;
    write_addr_fm   = '0;
    write_addr      = '0;
    set_exp_default();
    run_edges(1);

    // Reset state
    write_addr = 3'd5;
    #1;
    check("rst_result5", result, 16'h0005);
    check("rst_mem_write", {15'b0, mem_write}, 16'h0000);
    check("rst_show", show, 16'h0000);

    // ADD R1,R2 -> R2 = 3
    clear_mem();
    load_word(12'h020, 16'hC95F);
    reset = 1'b0;
    check("add_first_fetch", instruction, 16'hC95F);
    run_edges(2);
    check("add_show_ex", show, 16'h0003);
    run_edges(1);
    check("add_show_nop", show, 16'h0000);
    run_edges(1);
    write_addr = 3'd2;
    #1;
    check("add_r2_before_wb", result, 16'h0002);
    run_edges(1);
    exp_r[2] = 16'h0003;
    check_regs("add");

    // NOT R3 -> 0xFFFC
    begin_test();
    load_word(12'h020, 16'h1860);
    reset = 1'b0;
    run_edges(2);
    check("not_show_ex", show, 16'hFFFC);
    run_edges(3);
    exp_r[3] = 16'hFFFC;
    check_regs("not");

    // STD R1,R2 then LDD R2,R7 two slots later -> R7 = M[2] = 1
    begin_test();
    load_word(12'h020, 16'h615F);
    load_word(12'h022, 16'h22E0);
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      run_edges(1);
      check($sformatf("std_mw_e%0d", e), {15'b0, mem_write}, (e == 3) ? 16'h0001 : 16'h0000);
    end
    run_edges(3);
    exp_r[7] = 16'h0001;
    check_regs("ldd");

    // Back-to-back dependent ADDs read the stale R2: R3 = 2 + 3 = 5
    begin_test();
    load_word(12'h020, 16'hC95F);
    load_word(12'h021, 16'hCA60);
    reset = 1'b0;
    run_edges(7);
    exp_r[2] = 16'h0003;
    exp_r[3] = 16'h0005;
    check_regs("b2b");

    // Same pair with two NOPs between sees the new R2: R3 = 3 + 3 = 6
    begin_test();
    load_word(12'h020, 16'hC95F);
    load_word(12'h023, 16'hCA60);
    reset = 1'b0;
    run_edges(9);
    exp_r[2] = 16'h0003;
    exp_r[3] = 16'h0006;
    check_regs("spaced");

    // Loader write collides with a store to M[2]; loader data is kept
    begin_test();
    load_word(12'h020, 16'h615F);
    load_word(12'h024, 16'h22E0);
    reset = 1'b0;
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        run_edges(1);
        if (mem_write) found = 1'b1;
      end
      check("ldst_mw_seen", {15'b0, found}, 16'h0001);
    end
    write_addr_fm   = 32'h0000_0002;
    write_data_fm   = 16'hBEEF;
    write_enable_fm = 1'b1;
    run_edges(1);
    write_enable_fm = 1'b0;
    check("ldst_mw_after", {15'b0, mem_write}, 16'h0000);
    run_edges(6);
    exp_r[7] = 16'hBEEF;
    check_regs("ldst");

    // rst_fm clears memory and beats a simultaneous loader write
    begin_test();
    load_word(12'h020, 16'hC95F);
    load_word(12'h021, 16'h1860);
    load_word(12'h022, 16'h615F);
    load_word(12'h023, 16'h22E0);
    rst_fm          = 1'b1;
    write_enable_fm = 1'b1;
    write_addr_fm   = 32'h0000_0021;
    write_data_fm   = 16'h1234;
    run_edges(1);
    rst_fm          = 1'b0;
    write_enable_fm = 1'b0;
    reset           = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("clr_instr_%0d", i), instruction, 16'h0000);
      run_edges(1);
    end
    check_regs("clr");

    // Mid-run reset restores registers/PC and squashes an in-flight store
    begin_test();
    load_word(12'h000, 16'h5A5A);
    load_word(12'h020, 16'hC95F);
    load_word(12'h021, 16'h1860);
    load_word(12'h022, 16'h6100);
    reset = 1'b0;
    run_edges(5);
    write_addr = 3'd2;
    #1;
    check("mid_r2_before", result, 16'h0003);
    reset = 1'b1;
    #1;
    check("mid_pc_fetch", instruction, 16'hC95F);
    check("mid_mem_write", {15'b0, mem_write}, 16'h0000);
    check("mid_show", show, 16'h0000);
    check_regs("mid");
    run_edges(2);
    load_word(12'h020, 16'h20E0);
    load_word(12'h021, 16'h0000);
    load_word(12'h022, 16'h0000);
    reset = 1'b0;
    run_edges(6);
    exp_r[7] = 16'h5A5A;
    check_regs("squash");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
